systolic_result_reader: RTL and testbench

- Consumer end of the systolic array's completion interface.
- On the controller's one-cycle `done` pulse, snapshots the full NxN accumulator array.
- Streams the snapshot out one row per transfer on a valid/ready interface toward the output buffer or host.
- Tells the controller when a new computation may be started without clobbering unread results.

---
 rtl/systolic_result_reader.sv | 122 ++++++++++++
 tb/tb_systolic_result_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_reader.sv
// Snapshots the NxN accumulator array on the controller's done pulse and
// unloads it one row per valid/ready transfer toward the output buffer.
module systolic_result_reader #(
    parameter int  ARRAY_SIZE = 4,
    parameter int  ACC_WIDTH  = 32,
    localparam int ROW_W      = $clog2(ARRAY_SIZE)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      done_in,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*ACC_WIDTH-1:0] acc_flat,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]           out_data,
    output logic [ROW_W-1:0]                          out_row,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      start_allow,
    output logic                                      overrun,
    input  logic                                      clr_overrun
);

    localparam int ROW_BITS  = ARRAY_SIZE * ACC_WIDTH;
    localparam int SNAP_BITS = ARRAY_SIZE * ROW_BITS;

    // Handshake: a row moves when out_valid && out_ready on a rising edge;
    // once raised, out_valid and the row payload hold until that transfer.
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ROW_W-1:0]       r_row;
    logic [SNAP_BITS-1:0]   r_snap;
    logic                   r_overrun;

    logic                   w_xfer;
    logic                   w_row_last;
    logic                   w_capture;
    logic                   w_ovr_event;
    logic [ROW_BITS-1:0]    w_row_data;

    assign w_row_last  = (r_row == ROW_W'(ARRAY_SIZE - 1));
    assign w_xfer      = (r_state == S_STREAM) && out_ready;
    // A done pulse landing on the final transfer starts the next set seamlessly.
    assign w_capture   = done_in && ((r_state == S_IDLE) || (w_xfer && w_row_last));
    assign w_ovr_event = done_in && (r_state == S_STREAM) && !(w_xfer && w_row_last);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (done_in) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_xfer && w_row_last && !done_in) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid   = (r_state == S_STREAM);
        busy        = (r_state == S_STREAM);
        start_allow = (r_state != S_STREAM);
        out_last    = (r_state == S_STREAM) && w_row_last;
        out_row     = r_row;
        out_data    = w_row_data;
        overrun     = r_overrun;
    end

    // Row mux reads only the registered snapshot, never acc_flat.
    always_comb begin
        w_row_data = '0;
        for (int r = 0; r < ARRAY_SIZE; r++) begin
            if (r_row == ROW_W'(r)) begin
                w_row_data = r_snap[r*ROW_BITS +: ROW_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap <= '0;
            r_row  <= '0;
        end else if (w_capture) begin
            r_snap <= acc_flat;
            r_row  <= '0;
        end else if (w_xfer && !w_row_last) begin
            r_row  <= r_row + ROW_W'(1);
        end
    end

    // Sticky error flag; a new event outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_event) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_result_reader.sv
// Directed bench for systolic_result_reader: a row-queue model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_systolic_result_reader;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int ROW_W = $clog2(N);
    localparam int RB    = N * W;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 done_in = 1'b0;
    logic [N*N*W-1:0]     acc_flat = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [RB-1:0]        out_data;
    logic [ROW_W-1:0]     out_row;
    logic                 out_last;
    logic                 busy;
    logic                 start_allow;
    logic                 overrun;
    logic                 clr_overrun = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    systolic_result_reader #(.ARRAY_SIZE(N), .ACC_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .done_in     (done_in),
        .acc_flat    (acc_flat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .busy        (busy),
        .start_allow (start_allow),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [RB-1:0] act, input logic [RB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: queue of rows still owed downstream ----------------
    logic [ROW_W+RB-1:0] exp_q[$];
    logic                m_ovr = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_ovr = 1'b0;
        end else begin
            bit xfer;
            bit accept;
            xfer   = (exp_q.size() > 0) && out_ready;
            accept = (exp_q.size() == 0) || (xfer && exp_q.size() == 1);
            if (xfer) void'(exp_q.pop_front());
            if (done_in && accept) begin
                for (int r = 0; r < N; r++)
                    exp_q.push_back({ROW_W'(r), acc_flat[r*RB +: RB]});
            end
            if (done_in && !accept) m_ovr = 1'b1;
            else if (clr_overrun)   m_ovr = 1'b0;
        end
    end

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            bit have;
            have = (exp_q.size() > 0);
            chk("valid", RB'(out_valid), RB'(have));
            chk("busy", RB'(busy), RB'(have));
            chk("start_allow", RB'(start_allow), RB'(!have));
            chk("overrun", RB'(overrun), RB'(m_ovr));
            if (have) begin
                chk("data", out_data, exp_q[0][RB-1:0]);
                chk("row", RB'(out_row), RB'(exp_q[0][ROW_W+RB-1:RB]));
                chk("last", RB'(out_last), RB'(exp_q[0][ROW_W+RB-1:RB] == ROW_W'(N-1)));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_pattern(input int base);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                acc_flat[(r*N+c)*W +: W] = W'(base + 16*r + c);
    endtask

    function automatic logic [RB-1:0] row_of(input int base, input int r);
        logic [RB-1:0] v;
        for (int c = 0; c < N; c++) v[c*W +: W] = W'(base + 16*r + c);
        return v;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_set(input int base);
        load_pattern(base);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", RB'(out_valid), RB'(0));
        chk("rst_busy", RB'(busy), RB'(0));
        chk("rst_start_allow", RB'(start_allow), RB'(1));
        chk("rst_overrun", RB'(overrun), RB'(0));
        chk("rst_data", out_data, RB'(0));
        cycles(2);
        rst = 1'b0;
        cycles(1);

        // Basic unload
        out_ready = 1'b1;
        start_set(0);
        chk("basic_valid_lat1", RB'(out_valid), RB'(1));
        chk("basic_row0", RB'(out_row), RB'(0));
        chk("basic_last_row0", RB'(out_last), RB'(0));
        cycles(1);
        chk("basic_row1_data", out_data, {32'd19, 32'd18, 32'd17, 32'd16});
        cycles(2);
        chk("basic_row3", RB'(out_row), RB'(3));
        chk("basic_last_row3", RB'(out_last), RB'(1));
        cycles(1);
        chk("basic_idle_busy", RB'(busy), RB'(0));
        chk("basic_idle_start_allow", RB'(start_allow), RB'(1));
        chk("basic_idle_valid", RB'(out_valid), RB'(0));

        // Backpressure at row 2
        start_set(100);
        cycles(2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            chk("bp_hold_row", RB'(out_row), RB'(2));
            chk("bp_hold_data", out_data, row_of(100, 2));
            chk("bp_hold_valid", RB'(out_valid), RB'(1));
        end
        out_ready = 1'b1;
        cycles(1);
        chk("bp_row3_after", RB'(out_row), RB'(3));
        cycles(1);

        // Snapshot isolation
        start_set(200);
        acc_flat = '1;
        chk("iso_row0", out_data, row_of(200, 0));
        cycles(3);
        chk("iso_row3", out_data, row_of(200, 3));
        cycles(1);

        // Overrun during row 1, then clear
        start_set(300);
        cycles(1);
        load_pattern(400);
        done_in = 1'b1;
        cycles(1);
        done_in = 1'b0;
        chk("ovr_set", RB'(overrun), RB'(1));
        chk("ovr_row2_orig", out_data, row_of(300, 2));
        cycles(1);
        clr_overrun = 1'b1;
        cycles(1);
        clr_overrun = 1'b0;
        chk("ovr_cleared", RB'(overrun), RB'(0));

        // Set and clear in the same cycle: set wins
        start_set(500);
        cycles(1);
        done_in = 1'b1;
        clr_overrun = 1'b1;
        cycles(1);
        done_in = 1'b0;
        clr_overrun = 1'b0;
        chk("ovr_set_wins", RB'(overrun), RB'(1));
        cycles(1);
        clr_overrun = 1'b1;
        cycles(1);
        clr_overrun = 1'b0;
        chk("ovr_cleared2", RB'(overrun), RB'(0));

        // Back-to-back: done on row 3 transfer of set A
        start_set(600);
        cycles(3);
        load_pattern(700);
        done_in = 1'b1;
        cycles(1);
        done_in = 1'b0;
        chk("b2b_valid", RB'(out_valid), RB'(1));
        chk("b2b_row0", RB'(out_row), RB'(0));
        chk("b2b_data", out_data, {32'd703, 32'd702, 32'd701, 32'd700});
        chk("b2b_no_ovr", RB'(overrun), RB'(0));
        cycles(4);

        // Async reset mid-stream at row 2
        start_set(800);
        cycles(2);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", RB'(out_valid), RB'(0));
        chk("arst_busy", RB'(busy), RB'(0));
        chk("arst_start_allow", RB'(start_allow), RB'(1));
        chk("arst_row", RB'(out_row), RB'(0));
        chk("arst_data", out_data, RB'(0));
        cycles(1);
        rst = 1'b0;
        cycles(1);
        start_set(900);
        chk("arst_restart_row0", out_data, row_of(900, 0));
        cycles(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
